// File: rtl/mvau_stream_control_hs.sv
// MVAU stream control: sequences SIMD/PE folds over a buffered activation vector,
// with valid/ready handshakes on the activation input and the accumulator output.
module mvau_stream_control_hs #(
  parameter int unsigned SF           = 8,
  parameter int unsigned NF           = 2,
  parameter int unsigned SF_T         = 3,
  parameter int unsigned NF_T         = 1,
  parameter int unsigned WMEM_ADDR_BW = 4,
  parameter int unsigned NUM_REPS     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_v,
  output logic                    in_rdy,
  output logic                    ib_wen,
  output logic                    ib_ren,
  output logic [SF_T-1:0]         ib_addr,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    do_mac,
  output logic                    acc_clr,
  output logic                    sf_clr,
  output logic                    out_v,
  input  logic                    out_rdy,
  output logic [NF_T-1:0]         nf_cnt,
  output logic                    img_done
);

  typedef enum logic {FILL, REUSE} state_t;

  state_t          state_q, state_d;
  logic [SF_T-1:0] sf_cnt;
  logic [15:0]     rep_cnt;
  logic            last_q;
  logic            stall, fire;
  logic            sf_last, nf_last, rep_last;

  assign sf_last  = (sf_cnt == SF_T'(SF - 1));
  assign nf_last  = (nf_cnt == NF_T'(NF - 1));
  assign rep_last = (rep_cnt == 16'(NUM_REPS - 1));

  always_comb begin
    stall   = out_v & ~out_rdy;
    in_rdy  = 1'b0;
    fire    = 1'b0;
    ib_wen  = 1'b0;
    ib_ren  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        in_rdy = ~stall;
        fire   = in_v & ~stall;
        ib_wen = fire;
        if (fire && sf_last && (NF > 1)) state_d = REUSE;
      end
      REUSE: begin
        fire   = ~stall;
        ib_ren = fire;
        if (fire && sf_last && nf_last) state_d = FILL;
      end
    endcase
  end

  assign do_mac    = fire;
  assign acc_clr   = fire & (sf_cnt == '0);
  assign sf_clr    = fire & sf_last;
  assign ib_addr   = sf_cnt;
  assign wmem_addr = WMEM_ADDR_BW'(nf_cnt) * WMEM_ADDR_BW'(SF) + WMEM_ADDR_BW'(sf_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      sf_cnt   <= '0;
      nf_cnt   <= '0;
      rep_cnt  <= '0;
      out_v    <= 1'b0;
      last_q   <= 1'b0;
      img_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      // last_q is read before it is overwritten, so a same-cycle accept and new chunk stay distinct
      img_done <= out_v & out_rdy & last_q;
      if (fire) begin
        if (sf_last) begin
          sf_cnt <= '0;
          if (nf_last) begin
            nf_cnt  <= '0;
            rep_cnt <= rep_last ? '0 : rep_cnt + 1'b1;
          end else begin
            nf_cnt <= nf_cnt + 1'b1;
          end
        end else begin
          sf_cnt <= sf_cnt + 1'b1;
        end
      end
      if (sf_clr) begin
        out_v  <= 1'b1;
        last_q <= nf_last & rep_last;
      end else if (out_rdy) begin
        out_v <= 1'b0;
      end
    end
  end

endmodule
